// File: rtl/subleq_ctrl.sv
// SUBLEQ instruction sequencer: fetches A/B/C, performs mem[B] -= mem[A], steers subleq_pc.
// Optional `SUBLEQ_INSTR_COUNT_EN adds a saturating 32-bit executed-instruction counter.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_ctrl #(
  parameter int W = `WORD_SIZE,
  parameter logic [W-1:0] HALT_ADDR = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         run,
  input  logic [W-1:0] pc,
  output logic         pc_branch,
  output logic         pc_inc,
  output logic [W-1:0] pc_target,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic         halted
`ifdef SUBLEQ_INSTR_COUNT_EN
  ,
  output logic [31:0]  instr_count
`endif
);

  typedef enum logic [3:0] {
    IDLE, FA, FB, FC, LA, LB, WB, DEC, HALT
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]        op_a, op_b, op_c;
  logic signed [W-1:0] val_a, val_b, diff_wb;
  logic                leq_q;
  logic                xfer;

  function automatic logic is_leq(input logic signed [W-1:0] d);
    return (d == '0) || d[W-1];
  endfunction

  assign diff_wb = val_b - val_a;
  assign xfer    = mem_req & mem_ack;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      val_a <= '0;
      val_b <= '0;
      leq_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        case (state)
          FA:      op_a  <= mem_rdata;
          FB:      op_b  <= mem_rdata;
          FC:      op_c  <= mem_rdata;
          LA:      val_a <= mem_rdata;
          LB:      val_b <= mem_rdata;
          WB:      leq_q <= is_leq(diff_wb);
          default: ;
        endcase
      end
    end
  end

  // Request fields depend only on state and registered operands, so they hold until ack.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    pc_target = '0;
    halted    = 1'b0;
    case (state)
      IDLE: if (run) state_nxt = FA;
      FA, FB, FC: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          pc_inc    = 1'b1;
          state_nxt = (state == FA) ? FB : (state == FB) ? FC : LA;
        end
      end
      LA: begin
        mem_req  = 1'b1;
        mem_addr = op_a;
        if (mem_ack) state_nxt = LB;
      end
      LB: begin
        mem_req  = 1'b1;
        mem_addr = op_b;
        if (mem_ack) state_nxt = WB;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = op_b;
        mem_wdata = diff_wb;
        if (mem_ack) state_nxt = DEC;
      end
      DEC: begin
        if (leq_q && (op_c == HALT_ADDR)) begin
          state_nxt = HALT;
        end else begin
          if (leq_q) begin
            pc_branch = 1'b1;
            pc_target = op_c;
          end
          state_nxt = run ? FA : IDLE;
        end
      end
      HALT:    halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SUBLEQ_INSTR_COUNT_EN
  logic [31:0] count_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge areset) begin
    if (!areset)
      count_q <= '0;
    else if (state == DEC)
      count_q <= sat_inc(count_q);
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: behavioural memory + PC around the DUT, checked against a SUBLEQ interpreter.
`timescale 1ns/1ps

module tb_subleq_ctrl;

  logic        clk;
  logic        areset;
  logic        run;
  logic [15:0] pc;
  logic        pc_branch, pc_inc;
  logic [15:0] pc_target;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        halted;
`ifdef SUBLEQ_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  subleq_ctrl dut (
    .clk       (clk),
    .areset    (areset),
    .run       (run),
    .pc        (pc),
    .pc_branch (pc_branch),
    .pc_inc    (pc_inc),
    .pc_target (pc_target),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .halted    (halted)
`ifdef SUBLEQ_INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] ref_pc;
  int          ack_lat;
  int          ack_cnt;
  logic        pc_load;
  logic [15:0] pc_load_val;
  int          checks, errors;
  int          exp_cnt;
  bit          h;

  // Environment: zero-to-N wait-state memory and the PC register the DUT steers.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (ack_cnt >= ack_lat - 1);

  always @(posedge clk) begin
    if (!areset || !mem_req || mem_ack) ack_cnt <= 0;
    else                                ack_cnt <= ack_cnt + 1;
    if (pc_load)        pc <= pc_load_val;
    else if (pc_branch) pc <= pc_target;
    else if (pc_inc)    pc <= pc + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'h0;
      ref_mem[i] = 16'h0;
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic load_pc(input logic [15:0] v);
    @(negedge clk);
    pc_load_val = v;
    pc_load     = 1'b1;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    ref_pc  = v;
  endtask

  // Execute one instruction in the reference interpreter, then follow the DUT through it.
  task automatic exec_one(input bit stop, output bit halted_o);
    logic [15:0] p1, p2, a, b, c, va, vb, diff, nxt;
    logic [15:0] exp_addr [6];
    bit          leq, hlt;
    int          cyc, acc, guard;
    p1   = ref_pc + 16'd1;
    p2   = ref_pc + 16'd2;
    a    = ref_mem[ref_pc];
    b    = ref_mem[p1];
    c    = ref_mem[p2];
    va   = ref_mem[a];
    vb   = ref_mem[b];
    diff = vb - va;
    ref_mem[b] = diff;
    leq  = ($signed(diff) <= 0);
    hlt  = leq && (c == 16'hFFFF);
    nxt  = (leq && !hlt) ? c : ref_pc + 16'd3;
    exp_addr = '{ref_pc, p1, p2, a, b, b};

    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_req && guard < 50);
    chk("fetch_start", mem_req, 1);
    halted_o = 1'b0;
    if (!mem_req) return;

    cyc = 0;
    acc = 0;
    while (acc < 6 && cyc < 60) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (stop && cyc == 1) run = 1'b0;
      chk("req", mem_req, 1);
      chk("addr", mem_addr, exp_addr[acc]);
      chk("we", mem_we, acc == 5);
      if (acc == 5) chk("wdata", mem_wdata, diff);
      chk("inc", pc_inc, (acc < 3) && mem_ack);
      chk("branch_in_access", pc_branch, 0);
      if (mem_ack) begin
        if (acc == 5) mem[mem_addr] = mem_wdata;
        acc++;
      end
    end
    chk("access_count", acc, 6);

    @(negedge clk);
    cyc++;
    chk("dec_cycles", cyc, 6 * ack_lat + 1);
    chk("dec_req", mem_req, 0);
    chk("dec_inc", pc_inc, 0);
    chk("dec_branch", pc_branch, leq && !hlt);
    if (leq && !hlt) chk("dec_target", pc_target, c);
    exp_cnt++;
    @(posedge clk);
    #1;
    chk("halted", halted, hlt);
    chk("pc_after", pc, nxt);
    if (stop || hlt) chk("idle_req", mem_req, 0);
`ifdef SUBLEQ_INSTR_COUNT_EN
    chk("instr_count", instr_count, exp_cnt);
`endif
    ref_pc   = nxt;
    halted_o = hlt;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_cnt     = 0;
    areset      = 1'b0;
    run         = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 16'h0;
    ack_lat     = 1;
    ref_pc      = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_inc", pc_inc, 0);
    chk("rst_branch", pc_branch, 0);
    chk("rst_target", pc_target, 0);
    chk("rst_halted", halted, 0);
`ifdef SUBLEQ_INSTR_COUNT_EN
    chk("rst_count", instr_count, 0);
`endif
    areset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_req", mem_req, 0);

    // Test 1: basic negative result, branch to 6
    init_mem();
    poke(16'd0, 16'd3); poke(16'd1, 16'd4); poke(16'd2, 16'd6);
    poke(16'd3, 16'd5); poke(16'd4, 16'd2);
    load_pc(16'h0);
    run = 1'b1;
    exec_one(1'b1, h);
    chk("t1_mem4", mem[4], 16'hFFFD);

    // Tests 2 and 3: positive result falls through, then equal operands branch
    init_mem();
    poke(16'h20, 16'h30); poke(16'h21, 16'h31); poke(16'h22, 16'h40);
    poke(16'h30, 16'd4);  poke(16'h31, 16'd9);
    poke(16'h23, 16'h32); poke(16'h24, 16'h33); poke(16'h25, 16'h50);
    poke(16'h32, 16'd7);  poke(16'h33, 16'd7);
    load_pc(16'h20);
    run = 1'b1;
    exec_one(1'b0, h);
    exec_one(1'b1, h);
    chk("t2_mem31", mem[16'h31], 16'd5);
    chk("t3_mem33", mem[16'h33], 16'd0);

    // Test 5: two wait states per access
    init_mem();
    poke(16'd0, 16'd3); poke(16'd1, 16'd4); poke(16'd2, 16'd6);
    poke(16'd3, 16'd5); poke(16'd4, 16'd2);
    ack_lat = 3;
    load_pc(16'h0);
    run = 1'b1;
    exec_one(1'b1, h);
    chk("t5_mem4", mem[4], 16'hFFFD);
    ack_lat = 1;

    // Operand fetch wrapping past the top of memory
    init_mem();
    poke(16'hFFFF, 16'h70); poke(16'h0000, 16'h71); poke(16'h0001, 16'h20);
    poke(16'h70, 16'd1);    poke(16'h71, 16'd5);
    poke(16'h0002, 16'h72); poke(16'h0003, 16'h72); poke(16'h0004, 16'h30);
    poke(16'h72, 16'h1234);
    load_pc(16'hFFFF);
    run = 1'b1;
    exec_one(1'b0, h);
    exec_one(1'b1, h);

    // Randomized programs with random wait states
    for (int t = 0; t < 4; t++) begin
      init_mem();
      for (int i = 0; i < 20; i++) begin
        poke(16'(3 * i),     16'($urandom_range(64, 95)));
        poke(16'(3 * i + 1), 16'($urandom_range(64, 95)));
        poke(16'(3 * i + 2), 16'(3 * $urandom_range(0, 19)));
      end
      poke(16'd60, 16'd64); poke(16'd61, 16'd64); poke(16'd62, 16'd0);
      for (int d = 64; d < 96; d++)
        poke(16'(d), (t % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 20)));
      ack_lat = int'($urandom_range(1, 4));
      load_pc(16'h0);
      run = 1'b1;
      for (int n = 0; n < 15; n++) exec_one(n == 14, h);
    end
    ack_lat = 1;

    // Test 6: reset asserted during the B-operand load
    init_mem();
    poke(16'h100, 16'h140); poke(16'h101, 16'h141); poke(16'h102, 16'h120);
    poke(16'h140, 16'd1);   poke(16'h141, 16'd2);
    poke(16'h103, 16'h142); poke(16'h104, 16'h142); poke(16'h105, 16'h0);
    load_pc(16'h100);
    run = 1'b1;
    for (int g = 0; g < 50 && !mem_req; g++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("t6_lb_addr", mem_addr, 16'h141);
    areset = 1'b0;
    run    = 1'b0;
    #1;
    chk("t6_req", mem_req, 0);
    chk("t6_we", mem_we, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_inc", pc_inc, 0);
    chk("t6_branch", pc_branch, 0);
    chk("t6_halted", halted, 0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    areset = 1'b1;
    chk("t6_pc", pc, 16'h103);
    chk("t6_mem_untouched", mem[16'h141], 16'd2);
`ifdef SUBLEQ_INSTR_COUNT_EN
    chk("t6_count", instr_count, 0);
`endif
    ref_pc = 16'h103;
    run    = 1'b1;
    exec_one(1'b1, h);

    // Test 4: branch to HALT_ADDR, then run toggling has no effect
    init_mem();
    poke(16'd0, 16'h40); poke(16'd1, 16'h41); poke(16'd2, 16'hFFFF);
    poke(16'h40, 16'd3); poke(16'h41, 16'd2);
    load_pc(16'h0);
    run = 1'b1;
    exec_one(1'b0, h);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      run = 1'($urandom);
      chk("t4_halted", halted, 1);
      chk("t4_req", mem_req, 0);
    end
`ifdef SUBLEQ_INSTR_COUNT_EN
    chk("t4_count", instr_count, exp_cnt);
`endif
    areset = 1'b0;
    #1;
    chk("t4_rst_halted", halted, 0);
`ifdef SUBLEQ_INSTR_COUNT_EN
    chk("t4_rst_count", instr_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
